// File: rtl/vga_dtg_ss_if.sv
// Raster outputs of the display timing generator, bundled for the VGA consumers.
`timescale 1ns/1ps
interface vga_dtg_ss_if;
    logic [11:0] pixel_column;
    logic [11:0] pixel_row;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic        vblank_start;
    logic [15:0] frame_count;

    modport master (
        output pixel_column, pixel_row, video_on, hsync, vsync,
               frame_start, vblank_start, frame_count
    );
    modport slave (
        input  pixel_column, pixel_row, video_on, hsync, vsync,
               frame_start, vblank_start, frame_count
    );
endinterface

// File: rtl/vga_dtg_ss.sv
// Display timing generator: free-running raster counters with every output
// registered one clock behind them, plus per-frame strobes and a frame counter.
`timescale 1ns/1ps
module vga_dtg_ss #(
    parameter int H_VIS  = 1024,
    parameter int H_FP   = 24,
    parameter int H_SYNC = 136,
    parameter int H_BP   = 144,
    parameter int V_VIS  = 768,
    parameter int V_FP   = 3,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 29,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic           clk,
    input  logic           rstn,
    vga_dtg_ss_if.master   vga
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS_C  = 12'(H_VIS);
    localparam logic [11:0] V_VIS_C  = 12'(V_VIS);
    localparam logic [11:0] HS_START = 12'(H_VIS + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_VIS + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_VIS + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_VIS + V_FP + V_SYNC);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;

    logic [11:0] col_q;
    logic [11:0] row_q;
    logic        video_on_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        frame_start_q;
    logic        vblank_start_q;
    logic [15:0] frame_count_q;

    logic at_origin;
    assign at_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= 12'd0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    // Outputs all describe the counter position of the previous cycle, so
    // sync, video_on and the raster position stay mutually aligned.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q          <= 12'd0;
            row_q          <= 12'd0;
            video_on_q     <= 1'b0;
            hsync_q        <= ~HS_POL;
            vsync_q        <= ~VS_POL;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= 16'd0;
        end else begin
            col_q          <= h_cnt;
            row_q          <= v_cnt;
            video_on_q     <= (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
            hsync_q        <= ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
            vsync_q        <= ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
            frame_start_q  <= at_origin;
            vblank_start_q <= (h_cnt == 12'd0) && (v_cnt == V_VIS_C);
            if (at_origin) frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign vga.pixel_column = col_q;
    assign vga.pixel_row    = row_q;
    assign vga.video_on     = video_on_q;
    assign vga.hsync        = hsync_q;
    assign vga.vsync        = vsync_q;
    assign vga.frame_start  = frame_start_q;
    assign vga.vblank_start = vblank_start_q;
    assign vga.frame_count  = frame_count_q;
endmodule
